axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 slave responder backed by a word-addressed on-chip RAM array.
- Sits on the far side of the cache layer's AXI master port: it accepts the burst reads and writes that the caches, uncached path and crossbar emit.
- Used as the simulation/FPGA-lite memory target.
- Serves one transaction at a time and supports FIXED, INCR and WRAP bursts with configurable read latency.

Parameters:
- MEM_ADDR_BITS, 16, log2 of RAM depth in 32-bit words; word index = addr[MEM_ADDR_BITS+1:2], upper address bits ignored (aliasing).
- READ_LATENCY, 1, cycles from AR acceptance to first R beat valid (range 1..15).
- INIT_ZERO, 1, 1 = RAM contents cleared to 0 at elaboration; 0 = left uninitialised.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous and active-low
- arid  in  4  read ID
- araddr  in  32  read start address
- arlen  in  4  beats-1
- arsize  in  3  bytes per beat = 1<<arsize; only 0..2 legal
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  4  echoes arid
- rdata  out  32  read data
- rresp  out  2  response
- rlast  out  1  final beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- awid/awaddr/awlen/awsize/awburst/awvalid  in  4/32/4/3/2/1  write address channel, same encoding as AR
- awready  out  1  AW ready
- wid  in  4  write ID (ignored)
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  final write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  4  echoes awid
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- arlock/arcache/arprot/awlock/awcache/awprot are accepted and ignored (ports present, 2/4/3 bits).

Behaviour:
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.

Reset:
- State = IDLE.
- arready, awready, wready, rvalid, rlast, bvalid = 0.
- rid, bid, rdata, rresp, bresp = 0.
- Round-robin flag = 0 (favour read).
- RAM contents are not touched by reset.

IDLE:
- arready = awready = 1 only when the other channel is not being granted this cycle. Grant is combinational.
- Only AR valid: accept it. Only AW valid: accept it.
- Both valid: grant per round-robin flag; the flag flips after each granted transaction.
- On accept, latch id, start address, len, size and burst; clear the beat counter.
- AR accepted -> RD_WAIT. AW accepted -> WR_DATA.

RD_WAIT:
- Count READ_LATENCY-1 cycles, then assert rvalid with beat 0 data -> RD_DATA.
- With READ_LATENCY=1, rvalid rises the cycle after AR handshake.

RD_DATA:
- rdata/rid/rresp/rlast are held stable while rvalid && !rready.
- On the handshake, advance the address and present the next beat the following cycle, with no bubble: rvalid stays 1.
- rlast = 1 when beat counter == latched len.
- Handshake on the last beat -> IDLE with rvalid = 0.

WR_DATA:
- wready = 1. Each W handshake writes wdata to the RAM with byte-lane masking by wstrb, then advances the address.
- wlast on the beat where counter == len -> WR_RESP.
- wlast early, or missing at the final beat: transaction still ends at counter == len, and bresp = SLVERR (2'b10). Excess W beats are then not accepted until the next AW.

WR_RESP:
- bvalid = 1, bid = latched awid. Hold until bready; then -> IDLE.

Address advance (increment = 1<<size, computed on the 32-bit address):
- FIXED: address unchanged.
- INCR: addr + increment.
- WRAP: container = (len+1)<<size bytes. New addr = (addr & ~(container-1)) | ((addr+increment) & (container-1)).
- WRAP with len not in {1,3,7,15}: treated as INCR, response SLVERR.

Error responses:
- burst 2'b11 or size > 2: transaction completes normally in beat count; RAM is not written; rdata = 0; resp = SLVERR.
- Otherwise resp = OKAY.

Sub-word reads return the full 32-bit word; the master selects lanes.

Reset mid-transaction:
- Asynchronous return to IDLE; all valids drop immediately.
- Partially written bursts keep the beats already committed.

Test Plan:
- INCR read, araddr=0x100, arlen=3, arsize=2, RAM[0x40..0x43]=A,B,C,D, rready=1, READ_LATENCY=1 -> rvalid the cycle after AR handshake; rdata A,B,C,D on consecutive cycles; rlast only on D; rid echoed.
- WRAP read, araddr=0x108, arlen=3 -> word order 0x108, 0x10C, 0x100, 0x104; rresp=OKAY. Repeat with arlen=2 -> rresp=SLVERR on all 3 beats.
- INCR write, awaddr=0x200, awlen=1, beats 0x11223344 wstrb=4'b1111 then 0xAABBCCDD wstrb=4'b0011 over old 0xFFFFFFFF -> RAM[0x80]=0x11223344, RAM[0x81]=0xFFFFCCDD; one B beat, bresp=OKAY, bid=awid.
- Simultaneous arvalid and awvalid out of reset -> read granted first; after it completes, the still-pending write is granted.
- rready held low for 5 cycles mid-burst -> rdata/rlast stable throughout; no beat lost or duplicated.
- Write with awlen=3 but wlast on beat 1; separately, aresetn pulsed low mid-read burst -> write: bresp=SLVERR after the 4th beat; reset: rvalid=0 immediately, FSM in IDLE, arready=1 on the next cycle with arvalid high.

Source files
------------

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//
// AXI3 slave responder backed by a word-addressed on-chip RAM. Handles one
// transaction at a time (read or write), supporting FIXED, INCR and WRAP
// bursts with a configurable read latency. Used as the simulation /
// FPGA-lite memory target behind the cache layer's AXI master port.
//
// Parameters
//   MEM_ADDR_BITS : log2 of RAM depth in 32-bit words. Word index is
//                   addr[MEM_ADDR_BITS+1:2]; upper address bits alias.
//   READ_LATENCY  : cycles from AR acceptance to first R beat valid (1..15).
//   INIT_ZERO     : 1 = RAM cleared to zero at elaboration, 0 = uninitialised.
//
// Ports
//   aclk, aresetn            : clock, asynchronous active-low reset
//   ar* / arready            : read address channel (lock/cache/prot ignored)
//   r* / rready              : read data channel
//   aw* / awready            : write address channel (lock/cache/prot ignored)
//   w* / wready              : write data channel (wid ignored)
//   b* / bready              : write response channel
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int MEM_ADDR_BITS = 16,
    parameter int READ_LATENCY  = 1,
    parameter bit INIT_ZERO     = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // RD_WAIT lasts READ_LATENCY-1 cycles; the counter runs 0..WAIT_LAST.
    localparam int         WAIT_LAST_I = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam logic [3:0] WAIT_LAST   = WAIT_LAST_I[3:0];

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic wrap_len_ok(input logic [3:0] len);
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    function automatic logic [MEM_ADDR_BITS-1:0] word_idx(input logic [31:0] addr);
        word_idx = addr[MEM_ADDR_BITS+1:2];
    endfunction

    // Next beat address. Illegal burst type 2'b11 and WRAP with an illegal
    // length both step like INCR; the error response is tracked separately.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [3:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] inc;
        logic [31:0] container;
        logic [31:0] mask;
        inc       = 32'd1 << size;
        container = ({28'd0, len} + 32'd1) << size;
        mask      = container - 32'd1;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
            next_addr = (addr & ~mask) | ((addr + inc) & mask);
        end else begin
            next_addr = addr + inc;
        end
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        live_q, live_d;     // low during reset and the first cycle after
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  id_q, id_d;
    logic [3:0]  beat_q, beat_d;
    logic [3:0]  wait_q, wait_d;
    logic        rr_q, rr_d;         // 0 = favour read on contention
    logic        err_q, err_d;       // SLVERR for the whole transaction
    logic        bad_q, bad_d;       // illegal burst/size: no RAM write, rdata 0
    logic        werr_q, werr_d;     // wlast protocol error seen

    logic        ar_grant;
    logic        aw_grant;

    logic                     ram_re;
    logic                     ram_we;
    logic [MEM_ADDR_BITS-1:0] ram_raddr;
    logic [MEM_ADDR_BITS-1:0] ram_waddr;
    logic [31:0]              ram_rdata_q;

    logic [31:0] addr_adv;

    // Grant is combinational; on contention the round-robin flag decides.
    assign ar_grant = live_q && (state_q == IDLE) && arvalid && (!awvalid || !rr_q);
    assign aw_grant = live_q && (state_q == IDLE) && awvalid && (!arvalid || rr_q);

    assign addr_adv = next_addr(addr_q, len_q, size_q, burst_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        live_d    = 1'b1;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        rr_d      = rr_q;
        err_d     = err_q;
        bad_d     = bad_q;
        werr_d    = werr_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_raddr = word_idx(addr_q);
        ram_waddr = word_idx(addr_q);

        case (state_q)
            IDLE: begin
                if (ar_grant) begin
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    id_d      = arid;
                    beat_d    = 4'd0;
                    wait_d    = 4'd0;
                    rr_d      = ~rr_q;
                    bad_d     = (arburst == 2'b11) || (arsize > 3'd2);
                    err_d     = (arburst == 2'b11) || (arsize > 3'd2) ||
                                ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));
                    werr_d    = 1'b0;
                    // Fetch beat 0 now so a latency of 1 has data ready.
                    ram_re    = 1'b1;
                    ram_raddr = word_idx(araddr);
                    state_d   = (READ_LATENCY <= 1) ? RD_DATA : RD_WAIT;
                end else if (aw_grant) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    id_d    = awid;
                    beat_d  = 4'd0;
                    wait_d  = 4'd0;
                    rr_d    = ~rr_q;
                    bad_d   = (awburst == 2'b11) || (awsize > 3'd2);
                    err_d   = (awburst == 2'b11) || (awsize > 3'd2) ||
                              ((awburst == BURST_WRAP) && !wrap_len_ok(awlen));
                    werr_d  = 1'b0;
                    state_d = WR_DATA;
                end
            end

            RD_WAIT: begin
                ram_re = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    state_d = RD_DATA;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            RD_DATA: begin
                if (rready) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        // Prefetch the next beat on the handshake: no bubble.
                        addr_d    = addr_adv;
                        beat_d    = beat_q + 4'd1;
                        ram_re    = 1'b1;
                        ram_raddr = word_idx(addr_adv);
                    end
                end
            end

            WR_DATA: begin
                if (wvalid) begin
                    ram_we = !bad_q;
                    addr_d = addr_adv;
                    beat_d = beat_q + 4'd1;
                    if (beat_q == len_q) begin
                        // Beat count, not wlast, ends the burst.
                        if (!wlast) begin
                            werr_d = 1'b1;
                        end
                        state_d = WR_RESP;
                    end else if (wlast) begin
                        werr_d = 1'b1;
                    end
                end
            end

            WR_RESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            addr_q  <= 32'd0;
            len_q   <= 4'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            id_q    <= 4'd0;
            beat_q  <= 4'd0;
            wait_q  <= 4'd0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
            werr_q  <= werr_d;
        end
    end

    // -----------------------------------------------------------------------
    // RAM: byte-masked write port, registered read port (not reset).
    // -----------------------------------------------------------------------
    generate
        if (INIT_ZERO) begin : g_mem_zero
            logic [31:0] mem [DEPTH] = '{default: 32'h0};
            always_ff @(posedge aclk) begin
                if (ram_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wstrb[i]) begin
                            mem[ram_waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                        end
                    end
                end
                if (ram_re) begin
                    ram_rdata_q <= mem[ram_raddr];
                end
            end
        end else begin : g_mem_raw
            logic [31:0] mem [DEPTH];
            always_ff @(posedge aclk) begin
                if (ram_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wstrb[i]) begin
                            mem[ram_waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                        end
                    end
                end
                if (ram_re) begin
                    ram_rdata_q <= mem[ram_raddr];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs. All are decoded from reset flops, so they sit at zero while
    // aresetn is low and fall the instant it asserts.
    // -----------------------------------------------------------------------
    assign arready = live_q && (state_q == IDLE) && !aw_grant;
    assign awready = live_q && (state_q == IDLE) && !ar_grant;

    assign rvalid  = (state_q == RD_DATA);
    assign rlast   = rvalid && (beat_q == len_q);
    assign rid     = id_q;
    assign rresp   = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign rdata   = (rvalid && !bad_q) ? ram_rdata_q : 32'd0;

    assign wready  = (state_q == WR_DATA);

    assign bvalid  = (state_q == WR_RESP);
    assign bid     = id_q;
    assign bresp   = (bvalid && (err_q || werr_q)) ? RESP_SLVERR : RESP_OKAY;

    // Sideband inputs carry no meaning for this target.
    logic unused_inputs;
    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed self-checking bench for axi_sram_slave (READ_LATENCY = 1).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_sram_slave;

    localparam int TIMEOUT = 50;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [31:0] WA = 32'hAAAA_0100;
    localparam logic [31:0] WB = 32'hBBBB_0104;
    localparam logic [31:0] WC = 32'hCCCC_0108;
    localparam logic [31:0] WD = 32'hDDDD_010C;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, awvalid, awready;
    logic        rlast, rvalid, rready;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wd    [16];
    logic [3:0]  ws    [16];
    logic [31:0] exp_q [16];

    always #5 aclk = ~aclk;

    axi_sram_slave #(
        .MEM_ADDR_BITS (12),
        .READ_LATENCY  (1),
        .INIT_ZERO     (1'b1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arlock  (arlock),
        .arcache (arcache),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awlock  (awlock),
        .awcache (awcache),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (wid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < TIMEOUT) begin
            @(negedge aclk); #1; n++;
        end
        check_val("ar_handshake", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    // Read burst; expected data in exp_q. rready drops for 5 cycles at
    // stall_beat (-1 = never).
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] resp, input int stall_beat);
        rready = 1'b1;
        ar_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_beat) begin
                rready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    check_val("r_stall_valid", 32'(rvalid), 32'd1);
                    check_val("r_stall_data", rdata, exp_q[i]);
                    check_val("r_stall_last", 32'(rlast), 32'(i == int'(len)));
                    @(negedge aclk);
                end
                rready = 1'b1;
            end
            #1;
            check_val("r_valid", 32'(rvalid), 32'd1);
            check_val("r_data", rdata, exp_q[i]);
            check_val("r_last", 32'(rlast), 32'(i == int'(len)));
            check_val("r_id", 32'(rid), 32'(id));
            check_val("r_resp", 32'(rresp), 32'(resp));
            @(negedge aclk);
        end
        #1;
        check_val("r_end_valid", 32'(rvalid), 32'd0);
        rready = 1'b0;
        $display("[TB] read  id=%0d addr=0x%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    // Write burst with data wd/ws; wlast asserted on beat wlast_beat.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_beat, input logic [1:0] resp);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < TIMEOUT) begin
            @(negedge aclk); #1; n++;
        end
        check_val("aw_handshake", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_beat);
            #1;
            n = 0;
            while (!wready && n < TIMEOUT) begin
                @(negedge aclk); #1; n++;
            end
            check_val("w_ready", 32'(wready), 32'd1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        n = 0;
        while (!bvalid && n < TIMEOUT) begin
            @(negedge aclk); #1; n++;
        end
        check_val("b_valid", 32'(bvalid), 32'd1);
        check_val("b_wready_low", 32'(wready), 32'd0);
        check_val("b_id", 32'(bid), 32'(id));
        check_val("b_resp", 32'(bresp), 32'(resp));
        @(negedge aclk);
        bready = 1'b0;
        $display("[TB] write id=%0d addr=0x%08h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        arlock = '0; arcache = '0; arprot = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        awlock = '0; awcache = '0; awprot = '0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check_val("rst_arready", 32'(arready), 32'd0);
        check_val("rst_awready", 32'(awready), 32'd0);
        check_val("rst_wready", 32'(wready), 32'd0);
        check_val("rst_rvalid", 32'(rvalid), 32'd0);
        check_val("rst_rlast", 32'(rlast), 32'd0);
        check_val("rst_bvalid", 32'(bvalid), 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_ids", 32'({rid, bid}), 32'd0);
        check_val("rst_resps", 32'({rresp, bresp}), 32'd0);
        $display("[TB] reset checked");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // Preload 0x100..0x10C
        wd[0] = WA; wd[1] = WB; wd[2] = WC; wd[3] = WD;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd3, 32'h100, 4'd3, 3'd2, INCR, 3, OKAY);

        // INCR read, stall-free
        exp_q[0] = WA; exp_q[1] = WB; exp_q[2] = WC; exp_q[3] = WD;
        do_read(4'd5, 32'h100, 4'd3, 3'd2, INCR, OKAY, -1);

        // WRAP read, legal length: 0x108, 0x10C, 0x100, 0x104
        exp_q[0] = WC; exp_q[1] = WD; exp_q[2] = WA; exp_q[3] = WB;
        do_read(4'd6, 32'h108, 4'd3, 3'd2, WRAP, OKAY, -1);

        // WRAP read, illegal length: steps as INCR into zeroed 0x110
        exp_q[0] = WC; exp_q[1] = WD; exp_q[2] = 32'h0;
        do_read(4'd6, 32'h108, 4'd2, 3'd2, WRAP, SLVERR, -1);

        // Byte-masked INCR write over 0xFFFFFFFF
        wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hFFFF_FFFF; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd1, 32'h200, 4'd1, 3'd2, INCR, 1, OKAY);
        wd[0] = 32'h1122_3344; wd[1] = 32'hAABB_CCDD; ws[0] = 4'hF; ws[1] = 4'b0011;
        do_write(4'd9, 32'h200, 4'd1, 3'd2, INCR, 1, OKAY);
        exp_q[0] = 32'h1122_3344; exp_q[1] = 32'hFFFF_CCDD;
        do_read(4'd2, 32'h200, 4'd1, 3'd2, INCR, OKAY, -1);

        // rready held low 5 cycles on beat 1
        exp_q[0] = WA; exp_q[1] = WB; exp_q[2] = WC; exp_q[3] = WD;
        do_read(4'd7, 32'h100, 4'd3, 3'd2, INCR, OKAY, 1);

        // FIXED read returns the same word each beat
        exp_q[0] = WB; exp_q[1] = WB; exp_q[2] = WB;
        do_read(4'd8, 32'h104, 4'd2, 3'd2, FIXED, OKAY, -1);

        // Early wlast: all 4 beats still committed, SLVERR
        wd[0] = 32'h3000_0000; wd[1] = 32'h3000_0001; wd[2] = 32'h3000_0002; wd[3] = 32'h3000_0003;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd4, 32'h300, 4'd3, 3'd2, INCR, 1, SLVERR);
        for (int i = 0; i < 4; i++) exp_q[i] = wd[i];
        do_read(4'd4, 32'h300, 4'd3, 3'd2, INCR, OKAY, -1);

        // Illegal size write: RAM untouched, SLVERR
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(4'd6, 32'h100, 4'd0, 3'd3, INCR, 0, SLVERR);
        exp_q[0] = WA;
        do_read(4'd6, 32'h100, 4'd0, 3'd2, INCR, OKAY, -1);

        // Illegal burst type read: zero data, SLVERR, full beat count
        exp_q[0] = 32'h0; exp_q[1] = 32'h0;
        do_read(4'd7, 32'h100, 4'd1, 3'd2, 2'b11, SLVERR, -1);

        // Simultaneous AR and AW straight out of reset: read goes first
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        arid = 4'd1; araddr = 32'h100; arlen = 4'd0; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
        awid = 4'd2; awaddr = 32'h400; awlen = 4'd0; awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
        #1;
        check_val("arb_arready", 32'(arready), 32'd1);
        check_val("arb_awready", 32'(awready), 32'd0);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        check_val("arb_rvalid", 32'(rvalid), 32'd1);
        check_val("arb_rdata", rdata, WA);
        check_val("arb_rid", 32'(rid), 32'd1);
        check_val("arb_awready_busy", 32'(awready), 32'd0);
        @(negedge aclk);
        rready = 1'b0;
        #1;
        check_val("arb_awready_next", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wlast = 1'b1;
        #1;
        check_val("arb_wready", 32'(wready), 32'd1);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        check_val("arb_bvalid", 32'(bvalid), 32'd1);
        check_val("arb_bid", 32'(bid), 32'd2);
        check_val("arb_bresp", 32'(bresp), 32'(OKAY));
        @(negedge aclk);
        bready = 1'b0;
        $display("[TB] arbitration read-then-write done");
        exp_q[0] = 32'h5A5A_5A5A;
        do_read(4'd2, 32'h400, 4'd0, 3'd2, INCR, OKAY, -1);

        // Reset pulsed mid-read burst
        rready = 1'b1;
        ar_send(4'd7, 32'h100, 4'd7, 3'd2, INCR);
        #1;
        check_val("mid_beat0", rdata, WA);
        @(negedge aclk);
        #1;
        check_val("mid_beat1", rdata, WB);
        aresetn = 1'b0;
        #1;
        check_val("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_val("mid_rst_arready", 32'(arready), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        arid = 4'd4; araddr = 32'h104; arlen = 4'd0; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
        @(negedge aclk);
        #1;
        check_val("mid_arready_after", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        #1;
        check_val("mid_new_rvalid", 32'(rvalid), 32'd1);
        check_val("mid_new_rdata", rdata, WB);
        check_val("mid_new_rid", 32'(rid), 32'd4);
        check_val("mid_new_rlast", 32'(rlast), 32'd1);
        @(negedge aclk);
        #1;
        check_val("mid_new_end", 32'(rvalid), 32'd0);
        rready = 1'b0;
        $display("[TB] reset mid-burst recovery done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
